mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the processor's two bus initiators: instruction fetch and load/store.
- Accepts one request at a time over valid/ready, services it from an internal word-addressed SRAM model after a fixed latency, and holds the response until the initiator accepts it.
- Sits below the CPU top as the simulation and FPGA memory, replacing combinational memory access.

Parameters:
- BASE_ADDR, 64'h8000_0000, first byte address mapped to the array.
- DEPTH_LOG2, 12, log2 of the number of 64-bit words in the array.
- LATENCY, 2, cycles from request handshake to response valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request valid.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  64  fetch byte address.
- if_rsp_valid  out  1  fetch response valid.
- if_rsp_ready  in  1  fetch initiator accepts response.
- if_rsp_inst  out  32  fetched instruction.
- if_rsp_err  out  1  fetch address out of range or misaligned.
- ls_req_valid  in  1  load/store request valid.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_addr  in  64  load/store byte address.
- ls_wen  in  1  1 = store, 0 = load.
- ls_wdata  in  64  store data, aligned to the 64-bit word.
- ls_wmask  in  8  per-byte store enable.
- ls_rsp_valid  out  1  load/store response valid.
- ls_rsp_ready  in  1  load/store initiator accepts response.
- ls_rsp_rdata  out  64  full 64-bit word read; the initiator performs byte extraction.
- ls_rsp_err  out  1  address out of range.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (rst=0, asynchronous):
  - state=IDLE, latency counter=0, granted-port register=0.
  - All outputs 0.
  - Array contents are not reset.
- Reset asserted mid-transaction: the transaction is dropped. A store not yet committed is not written.
- Ready rules:
  - In IDLE, ls_req_ready = ls_req_valid.
  - In IDLE, if_req_ready = if_req_valid & ~ls_req_valid.
  - Both readies are 0 in ACCESS and RESP.
  - Fixed priority: load/store beats fetch on simultaneous requests.
- IDLE -> ACCESS on any request handshake:
  - Latch address, wen, wdata, wmask and granted port.
  - Load counter with LATENCY-1.
- ACCESS:
  - Counter decrements each cycle while nonzero.
  - On the cycle the counter is 0, the next edge moves to RESP.
  - On that same edge: the read word is captured, the store is committed with byte mask, and the err flag is registered.
- Timing: a handshake at edge k gives rsp_valid high after edge k+LATENCY.
- RESP:
  - The granted port's rsp_valid is 1, with data and err held stable.
  - Return to IDLE on the edge where rsp_valid & rsp_ready.
  - No new request is accepted in that cycle; the earliest next handshake is one cycle later.
- Address mapping:
  - word index = (addr - BASE_ADDR) >> 3, truncated to DEPTH_LOG2 bits.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 8*2^DEPTH_LOG2.
- Fetch:
  - if_rsp_inst = addr[2] ? word[63:32] : word[31:0].
  - addr[1:0] != 0 sets if_rsp_err.
- Errors:
  - Out-of-range load or fetch: data 0, err=1.
  - Out-of-range store: no write, err=1.
- ls_addr[2:0] is ignored for word selection; misalignment is the initiator's concern.
- A store with wmask=0 completes normally with no array change.
- ls_rsp_rdata on a store response returns the pre-write word.
- Inactive port's response outputs are 0.

Optional Feature:
- Macro: MEM_RESPONDER_TRACE_EN.
  - When defined: on each response handshake, simulation prints $display with cycle count, port (IF/LS), R/W, address, data, wmask and err.
  - A 64-bit cycle counter reset to 0 is compiled in for this purpose.
- When undefined: no counter and no display. Logic is identical otherwise and there are no port changes.

Test Plan:
- Fetch at 0x8000_0004 after preloading word0 = 64'h00000013_00100093, LATENCY=2, if_rsp_ready=1:
  - if_rsp_valid rises 2 cycles after the handshake.
  - if_rsp_inst = 32'h00000013, err=0.
- Store 64'hDEAD_BEEF_0123_4567 at 0x8000_0010 with wmask=8'h0F, then load the same address:
  - ls_rsp_rdata = 64'h0000_0000_0123_4567 (array previously 0).
- Simultaneous if_req_valid and ls_req_valid in IDLE:
  - ls granted first.
  - Fetch is granted only after the ls response handshake plus one idle cycle.
  - if_req_ready = 0 throughout.
- Hold ls_rsp_ready=0 for 5 cycles during RESP:
  - ls_rsp_valid and data stay stable.
  - Both req_readys stay 0.
  - Return to IDLE on the accept edge.
- Load at 0x7FFF_FFF8 and fetch at 0x8000_0002:
  - Each responds with err=1 and data 0.
  - A store to 0x7FFF_FFF8 leaves the array unchanged.
- Drive rst low during ACCESS of a store, then release:
  - All outputs 0 immediately.
  - The target word is unchanged.
  - The next request is accepted normally.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port memory responder arbitrating fetch and load/store initiators over valid/ready.
// Optional cycle-stamped response trace: define MEM_RESPONDER_TRACE_EN.
module mem_responder #(
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_addr,
   output logic        if_rsp_valid,
   input  logic        if_rsp_ready,
   output logic [31:0] if_rsp_inst,
   output logic        if_rsp_err,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic [63:0] ls_addr,
   input  logic        ls_wen,
   input  logic [63:0] ls_wdata,
   input  logic [7:0]  ls_wmask,
   output logic        ls_rsp_valid,
   input  logic        ls_rsp_ready,
   output logic [63:0] ls_rsp_rdata,
   output logic        ls_rsp_err
);

   localparam int unsigned NWORDS   = 1 << DEPTH_LOG2;
   localparam logic [63:0] LIMIT    = BASE_ADDR + (64'd8 << DEPTH_LOG2);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        port_q, port_d;   // 1 = load/store, 0 = fetch
   logic [63:0] addr_q, addr_d;
   logic        wen_q, wen_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wmask_q, wmask_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [63:0] mem [NWORDS];

   logic [DEPTH_LOG2-1:0] word_idx;
   logic [63:0]           mem_word;
   logic                  in_range;
   logic                  misaligned;
   logic                  acc_err;
   logic                  commit;
   logic                  do_write;
   logic                  rsp_hs;

   assign word_idx   = DEPTH_LOG2'((addr_q - BASE_ADDR) >> 3);
   assign mem_word   = mem[word_idx];
   assign in_range   = (addr_q >= BASE_ADDR) && (addr_q < LIMIT);
   assign misaligned = ~port_q & (addr_q[1:0] != 2'b00);
   assign acc_err    = ~in_range | misaligned;
   assign commit     = (state_q == ACCESS) && (cnt_q == '0);
   assign do_write   = rst & commit & port_q & wen_q & in_range;

   assign if_rsp_valid = (state_q == RESP) & ~port_q;
   assign ls_rsp_valid = (state_q == RESP) & port_q;
   assign rsp_hs       = (if_rsp_valid & if_rsp_ready) | (ls_rsp_valid & ls_rsp_ready);

   // Response payload is zeroed on whichever port is not currently answering.
   assign if_rsp_inst  = if_rsp_valid ? (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]) : '0;
   assign if_rsp_err   = if_rsp_valid & err_q;
   assign ls_rsp_rdata = ls_rsp_valid ? rdata_q : '0;
   assign ls_rsp_err   = ls_rsp_valid & err_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      port_d       = port_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;

      case (state_q)
         IDLE: begin
            // Load/store has fixed priority; readies are forced low while reset is held.
            ls_req_ready = ls_req_valid & rst;
            if_req_ready = if_req_valid & ~ls_req_valid & rst;
            if (ls_req_valid) begin
               state_d = ACCESS;
               cnt_d   = CNT_INIT;
               port_d  = 1'b1;
               addr_d  = ls_addr;
               wen_d   = ls_wen;
               wdata_d = ls_wdata;
               wmask_d = ls_wmask;
            end else if (if_req_valid) begin
               state_d = ACCESS;
               cnt_d   = CNT_INIT;
               port_d  = 1'b0;
               addr_d  = if_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               rdata_d = acc_err ? '0 : mem_word;
               err_d   = acc_err;
            end
         end
         RESP: begin
            if (rsp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         port_q  <= 1'b0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         port_q  <= port_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Commit shares the edge that captures the pre-write word into rdata_q.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (wmask_q[b]) mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

`ifdef MEM_RESPONDER_TRACE_EN
   logic [63:0] cyc_q, cyc_d;

   assign cyc_d = cyc_q + 64'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc_q <= '0;
      else      cyc_q <= cyc_d;
   end

   always_ff @(posedge clk) begin
      if (rst && rsp_hs) begin
         $display("[%0d] %s %s addr=%h data=%h wmask=%h err=%b",
                  cyc_q, port_q ? "LS" : "IF", (port_q & wen_q) ? "W" : "R",
                  addr_q, rdata_q, wmask_q, err_q);
      end
   end
`endif

endmodule
